ro_puf_ctrl: RTL and testbench

Measurement controller for the RO PUF counter pair. It sits on the system clock domain and drives the counter pair's clear and enable inputs. It steps the RO-pair select through RESP_BITS challenges. For each challenge it reads back the two 8-bit counts, compares them and assembles a RESP_BITS-wide response word, delivered with a busy/done handshake.

---
 rtl/ro_puf_ctrl_if.sv | 27 ++
 rtl/ro_puf_ctrl.sv | 135 +++++++++++++
 tb/tb_ro_puf_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_ctrl_if.sv
// Bundle between the RO PUF measurement controller, its requester and the RO counter pair.
// The slave side is the controller. The master side is the requester and the counter pair.
interface ro_puf_ctrl_if #(
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 3
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic                 tie;
    logic [SEL_W-1:0]     ro_sel;
    logic                 cnt_reset;
    logic                 cnt_enable;
    logic [7:0]           count1;
    logic [7:0]           count2;

    modport master (
        output start, count1, count2,
        input  busy, done, response, tie, ro_sel, cnt_reset, cnt_enable
    );

    modport slave (
        input  start, count1, count2,
        output busy, done, response, tie, ro_sel, cnt_reset, cnt_enable
    );
endinterface

// File: rtl/ro_puf_ctrl.sv
// RO PUF measurement controller. It clears, runs and settles the counter pair once per challenge.
// It then compares the synchronised counts into one response bit.
module ro_puf_ctrl #(
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 3,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 4
) (
    input logic         clk,
    input logic         reset_n,
    ro_puf_ctrl_if.slave bus
);
    localparam int WIN_W = $clog2(WINDOW);
    localparam int SET_W = $clog2(SETTLE);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {IDLE, CLR, RUN, SETL, CMP, DONE} state_t;

    state_t               state;
    logic [7:0]           c1_s1, c1_s2, c2_s1, c2_s2;
    logic                 clr_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic [SET_W-1:0]     set_cnt;
    logic                 busy_r, done_r, tie_r, cnt_reset_r, cnt_enable_r;
    logic [RESP_BITS-1:0] response_r;
    logic [SEL_W-1:0]     ro_sel_r;
    logic                 sat_armed, saturated;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1_s1 <= '0;
            c1_s2 <= '0;
            c2_s1 <= '0;
            c2_s2 <= '0;
        end else begin
            c1_s1 <= bus.count1;
            c1_s2 <= c1_s1;
            c2_s1 <= bus.count2;
            c2_s2 <= c2_s1;
        end
    end

    // The first RUN cycles may still show the previous pair's counts in the synchroniser.
    assign sat_armed = 32'(win_cnt) >= 32'd2;
    assign saturated = sat_armed && ((c1_s2 == 8'hFF) || (c2_s2 == 8'hFF));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            response_r   <= '0;
            tie_r        <= 1'b0;
            ro_sel_r     <= '0;
            cnt_enable_r <= 1'b0;
            cnt_reset_r  <= 1'b1;
            clr_cnt      <= 1'b0;
            win_cnt      <= '0;
            set_cnt      <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt_reset_r  <= 1'b1;
                    cnt_enable_r <= 1'b0;
                    if (bus.start) begin
                        state      <= CLR;
                        busy_r     <= 1'b1;
                        response_r <= '0;
                        tie_r      <= 1'b0;
                        ro_sel_r   <= '0;
                        clr_cnt    <= 1'b0;
                    end
                end
                CLR: begin
                    clr_cnt <= 1'b1;
                    if (clr_cnt) begin
                        state        <= RUN;
                        cnt_reset_r  <= 1'b0;
                        cnt_enable_r <= 1'b1;
                        win_cnt      <= '0;
                    end
                end
                RUN: begin
                    if (win_cnt == WIN_LAST || saturated) begin
                        state        <= SETL;
                        cnt_enable_r <= 1'b0;
                        set_cnt      <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                SETL: begin
                    if (set_cnt == SET_LAST) begin
                        state <= CMP;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                CMP: begin
                    // Equal counts naturally write 0 here; the tie flag records the ambiguity.
                    response_r[ro_sel_r] <= (c1_s2 > c2_s2);
                    if (c1_s2 == c2_s2) begin
                        tie_r <= 1'b1;
                    end
                    if (ro_sel_r == SEL_LAST) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        ro_sel_r    <= ro_sel_r + 1'b1;
                        state       <= CLR;
                        cnt_reset_r <= 1'b1;
                        clr_cnt     <= 1'b0;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cnt_reset_r <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.response   = response_r;
    assign bus.tie        = tie_r;
    assign bus.ro_sel     = ro_sel_r;
    assign bus.cnt_reset  = cnt_reset_r;
    assign bus.cnt_enable = cnt_enable_r;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl, with a behavioural RO counter-pair model.
// It combines table vectors, hand-written corner sequences and randomised rates against a reference model.
module tb_ro_puf_ctrl;
    localparam int RESP_BITS = 8;
    localparam int SEL_W     = 3;
    localparam int WINDOW    = 64;
    localparam int SETTLE    = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    ro_puf_ctrl_if #(.RESP_BITS(RESP_BITS), .SEL_W(SEL_W)) bus ();

    ro_puf_ctrl #(
        .RESP_BITS(RESP_BITS),
        .SEL_W    (SEL_W),
        .WINDOW   (WINDOW),
        .SETTLE   (SETTLE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        int         r1e, r2e, r1o, r2o;
        int         tie_pair;
        logic [7:0] exp_resp;
        logic       exp_tie;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;

    int r1[RESP_BITS], r2[RESP_BITS], cap1[RESP_BITS], cap2[RESP_BITS];
    int jmp1[RESP_BITS], jmp2[RESP_BITS];
    int exp_en[RESP_BITS];
    logic [RESP_BITS-1:0] model_resp;
    logic model_tie;

    int   en_log[$];
    int   sel_log[$];
    int   en_cnt = 0, run_sel = 0, sel_unstable = 0, excl_bad = 0, n = 0;
    logic prev_en = 1'b0;

    // Counter value after cnt enabled cycles: rate/4 per clock, clipped at cap, or jumping to FF at jmp.
    function automatic int chanVal(input int rate, input int cap, input int jmp, input int cnt);
        int v;
        if (jmp != 0 && cnt >= jmp) return 255;
        v = cnt * rate / 4;
        if (v > cap) v = cap;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Enable stays high for WINDOW cycles, or stops two sync cycles after a count first reads FF.
    task automatic computeModel();
        model_resp = '0;
        model_tie  = 1'b0;
        for (int i = 0; i < RESP_BITS; i++) begin
            int  nen, e1, e2;
            bit  found;
            nen   = WINDOW;
            found = 1'b0;
            for (int k = 1; k <= WINDOW; k++) begin
                if (!found && (chanVal(r1[i], cap1[i], jmp1[i], k) == 255 ||
                               chanVal(r2[i], cap2[i], jmp2[i], k) == 255)) begin
                    found = 1'b1;
                    nen   = (k + 2 < WINDOW) ? k + 2 : WINDOW;
                end
            end
            exp_en[i]     = nen;
            e1            = chanVal(r1[i], cap1[i], jmp1[i], nen);
            e2            = chanVal(r2[i], cap2[i], jmp2[i], nen);
            model_resp[i] = (e1 > e2);
            if (e1 == e2) model_tie = 1'b1;
        end
    endtask

    task automatic loadPattern(input int r1e, input int r2e, input int r1o, input int r2o, input int tie_pair);
        for (int i = 0; i < RESP_BITS; i++) begin
            r1[i]   = (i % 2 == 0) ? r1e : r1o;
            r2[i]   = (i % 2 == 0) ? r2e : r2o;
            cap1[i] = 255;
            cap2[i] = 255;
            jmp1[i] = 0;
            jmp2[i] = 0;
            if (i == tie_pair) begin
                r1[i]   = 4;
                r2[i]   = 4;
                cap1[i] = 10;
                cap2[i] = 10;
            end
        end
    endtask

    // Monitor first, then the counter pair advances on the half-cycle after the controller's outputs change.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.cnt_reset && bus.cnt_enable) excl_bad++;
                if (bus.cnt_enable) begin
                    if (!prev_en) run_sel = int'(bus.ro_sel);
                    else if (int'(bus.ro_sel) != run_sel) sel_unstable++;
                    en_cnt++;
                end else if (prev_en) begin
                    en_log.push_back(en_cnt);
                    sel_log.push_back(run_sel);
                    en_cnt = 0;
                end
                prev_en = bus.cnt_enable;
            end else begin
                prev_en = 1'b0;
                en_cnt  = 0;
            end
            if (bus.cnt_reset) n = 0;
            else if (bus.cnt_enable) n++;
            bus.count1 = 8'(chanVal(r1[bus.ro_sel], cap1[bus.ro_sel], jmp1[bus.ro_sel], n));
            bus.count2 = 8'(chanVal(r2[bus.ro_sel], cap2[bus.ro_sel], jmp2[bus.ro_sel], n));
        end
    end

    task automatic startRequest(input string name);
        en_log.delete();
        sel_log.delete();
        sel_unstable = 0;
        excl_bad     = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({name, "_busy"}, bus.busy, 1);
        checkOutput({name, "_clr_resp"}, bus.response, 0);
        checkOutput({name, "_clr_tie"}, bus.tie, 0);
        checkOutput({name, "_sel0"}, bus.ro_sel, 0);
        checkOutput({name, "_clr_cnt_reset"}, bus.cnt_reset, 1);
    endtask

    task automatic finishRequest(input string name, input logic [7:0] exp_resp, input logic exp_tie, input bit hold);
        bit ok;
        ok = 1'b0;
        if (hold) bus.start = 1'b1;
        for (int c = 0; c < 3000 && !ok; c++) begin
            if (bus.done === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no_done expected=done_within_3000", name);
            bus.start = 1'b0;
        end else begin
            checkOutput({name, "_done_busy"}, bus.busy, 0);
            checkOutput({name, "_resp"}, bus.response, exp_resp);
            checkOutput({name, "_tie"}, bus.tie, exp_tie);
            checkOutput({name, "_runs"}, en_log.size(), RESP_BITS);
            for (int i = 0; i < RESP_BITS && i < en_log.size(); i++) begin
                checkOutput($sformatf("%s_en_cycles%0d", name, i), en_log[i], exp_en[i]);
                checkOutput($sformatf("%s_sel%0d", name, i), sel_log[i], i);
            end
            checkOutput({name, "_sel_stable"}, sel_unstable, 0);
            checkOutput({name, "_excl"}, excl_bad, 0);
            @(negedge clk);
            checkOutput({name, "_done_pulse"}, bus.done, 0);
            checkOutput({name, "_resp_held"}, bus.response, exp_resp);
            checkOutput({name, "_idle_busy"}, bus.busy, 0);
            if (hold) begin
                @(negedge clk);
                checkOutput({name, "_restart_busy"}, bus.busy, 1);
                checkOutput({name, "_restart_resp"}, bus.response, 0);
                bus.start = 1'b0;
                en_log.delete();
                sel_log.delete();
                sel_unstable = 0;
                excl_bad     = 0;
            end
        end
    endtask

    task automatic applyStimulus(input string name, input logic [7:0] exp_resp, input logic exp_tie);
        startRequest(name);
        finishRequest(name, exp_resp, exp_tie, 1'b0);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen_done;
        bit ok;

        vecs[0] = '{"all_fast",  3, 2, 3, 2, -1, 8'hFF, 1'b0};
        vecs[1] = '{"alternate", 3, 2, 2, 3, -1, 8'h55, 1'b0};
        vecs[2] = '{"tie3",      3, 2, 3, 2,  3, 8'hF7, 1'b1};
        vecs[3] = '{"no_tie",    2, 3, 2, 3, -1, 8'h00, 1'b0};
        vecs[4] = '{"odd_only",  1, 2, 5, 4, -1, 8'hAA, 1'b0};
        vecs[5] = '{"zero",      0, 0, 0, 0, -1, 8'h00, 1'b1};

        bus.start  = 1'b0;
        bus.count1 = 8'h00;
        bus.count2 = 8'h00;
        loadPattern(3, 2, 3, 2, -1);

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_resp", bus.response, 0);
        checkOutput("rst_tie", bus.tie, 0);
        checkOutput("rst_sel", bus.ro_sel, 0);
        checkOutput("rst_en", bus.cnt_enable, 0);
        checkOutput("rst_cnt_reset", bus.cnt_reset, 1);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_cnt_reset", bus.cnt_reset, 1);

        foreach (vecs[v]) begin
            loadPattern(vecs[v].r1e, vecs[v].r2e, vecs[v].r1o, vecs[v].r2o, vecs[v].tie_pair);
            computeModel();
            applyStimulus(vecs[v].name, vecs[v].exp_resp, vecs[v].exp_tie);
        end

        // Pair 0 jumps to FF on its 20th enabled cycle; enable must stop two sync cycles later.
        loadPattern(3, 2, 3, 2, -1);
        r1[0]   = 1;
        jmp1[0] = 20;
        computeModel();
        applyStimulus("sat", 8'hFF, 1'b0);
        if (en_log.size() > 0) checkOutput("sat_en_cycles_fixed", en_log[0], 22);

        // Reset asserted while pair 5 is settling.
        loadPattern(3, 2, 3, 2, -1);
        computeModel();
        startRequest("abort");
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            if (sel_log.size() >= 6) ok = 1'b1;
            else @(negedge clk);
        end
        checkOutput("abort_reached_settle", ok, 1);
        checkOutput("abort_sel5", bus.ro_sel, 5);
        checkOutput("abort_settle_en", bus.cnt_enable, 0);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_en", bus.cnt_enable, 0);
        checkOutput("abort_cnt_reset", bus.cnt_reset, 1);
        checkOutput("abort_resp", bus.response, 0);
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        checkOutput("abort_no_done", seen_done, 0);
        applyStimulus("after_abort", 8'hFF, 1'b0);

        // Start pulsed mid-request is ignored; start held through DONE re-launches at once.
        loadPattern(3, 2, 2, 3, -1);
        computeModel();
        startRequest("ignore");
        repeat (150) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finishRequest("ignore", 8'h55, 1'b0, 1'b1);
        finishRequest("held", 8'h55, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < RESP_BITS; i++) begin
                r1[i]   = int'($urandom_range(0, 7));
                r2[i]   = ($urandom_range(0, 3) == 0) ? r1[i] : int'($urandom_range(0, 7));
                cap1[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 120)) : 255;
                cap2[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 120)) : 255;
                jmp1[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 70)) : 0;
                jmp2[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 70)) : 0;
            end
            computeModel();
            applyStimulus($sformatf("rand%0d", t), model_resp, model_tie);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
